// File: rtl/slink_apb_ini.sv
// slink_apb_ini
//   APB initiator at the far end of the S-Link APB tunnel. Pops read/write
//   request packets from the generic flow-control L2A interface, replays each
//   one as a single APB master transfer, then returns a response packet on A2L.
//   One transaction in flight at a time.
//
// Ports
//   apb_clk, apb_reset_n   clock, async active-low reset
//   enable                 block enable (synchronous to apb_clk)
//   l2a_valid/data/accept  request packet in: [7:0] DT, [23:8] WC,
//                          [55:24] addr, [87:56] wdata; accept is combinational
//   a2l_valid/data/ready   response packet out: [7:0] DT, [23:8] WC,
//                          [56:24] payload
//   apb_*                  APB master
//   bad_pkt                one-cycle pulse when a malformed request is dropped
//   busy                   high whenever the FSM is not IDLE
//
// Optional build macro
//   SLINK_APB_INI_TIMEOUT_EN : ACCESS gives up after TIMEOUT_CYCLES cycles
//   without pready and reports pslverr=1, prdata=0. Without the macro ACCESS
//   waits for pready indefinitely.

module slink_apb_ini #(
  parameter logic [7:0] APB_READ_DT      = 8'h30,
  parameter logic [7:0] APB_READ_RSP_DT  = 8'h31,
  parameter logic [7:0] APB_WRITE_DT     = 8'h32,
  parameter logic [7:0] APB_WRITE_RSP_DT = 8'h33,
  parameter int         TIMEOUT_CYCLES   = 256
) (
  input  logic        apb_clk,
  input  logic        apb_reset_n,
  input  logic        enable,
  input  logic        l2a_valid,
  input  logic [87:0] l2a_data,
  output logic        l2a_accept,
  output logic        a2l_valid,
  output logic [56:0] a2l_data,
  input  logic        a2l_ready,
  output logic [31:0] apb_paddr,
  output logic        apb_pwrite,
  output logic        apb_psel,
  output logic        apb_penable,
  output logic [31:0] apb_pwdata,
  input  logic [31:0] apb_prdata,
  input  logic        apb_pready,
  input  logic        apb_pslverr,
  output logic        bad_pkt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RSP} state_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [15:0] wc;
    logic [7:0]  dt;
  } req_t;

  state_t      state, state_d;
  req_t        req;
  logic        take, is_rd, is_wr, acc_done, acc_tout;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [56:0] rsp_data;

  assign req   = req_t'(l2a_data);
  assign take  = (state == IDLE) && enable && l2a_valid;
  assign is_rd = (req.dt == APB_READ_DT)  && (req.wc == 16'd4);
  assign is_wr = (req.dt == APB_WRITE_DT) && (req.wc == 16'd8);

  // Every packet presented in an enabled IDLE cycle is popped, good or bad.
  assign l2a_accept = take;

`ifdef SLINK_APB_INI_TIMEOUT_EN
  localparam int            TW    = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt;

  // Counts ACCESS cycles; cleared whenever we are elsewhere.
  always_ff @(posedge apb_clk or negedge apb_reset_n) begin
    if (!apb_reset_n)          tcnt <= '0;
    else if (state != ACCESS)  tcnt <= '0;
    else                       tcnt <= tcnt + 1'b1;
  end

  assign acc_tout = (state == ACCESS) && !apb_pready && (tcnt == TLAST);
`else
  assign acc_tout = 1'b0;
`endif

  assign acc_done = (state == ACCESS) && (apb_pready || acc_tout);

  // A timed-out access has no pready; report it as a slave error with no data.
  always_comb begin
    rsp_err   = apb_pready ? apb_pslverr : 1'b1;
    rsp_rdata = apb_pready ? apb_prdata  : 32'd0;
    if (apb_pwrite) rsp_data = {32'd0, rsp_err, 16'd1, APB_WRITE_RSP_DT};
    else            rsp_data = {rsp_err, rsp_rdata, 16'd5, APB_READ_RSP_DT};
  end

  always_ff @(posedge apb_clk or negedge apb_reset_n) begin
    if (!apb_reset_n) state <= IDLE;
    else              state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (take && (is_rd || is_wr)) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (acc_done) state_d = RSP;
      RSP:     if (a2l_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered one step ahead of the state they belong to, so
  // psel appears with SETUP, penable with ACCESS and a2l_valid with RSP.
  always_ff @(posedge apb_clk or negedge apb_reset_n) begin
    if (!apb_reset_n) begin
      a2l_valid   <= 1'b0;
      a2l_data    <= '0;
      apb_paddr   <= '0;
      apb_pwrite  <= 1'b0;
      apb_psel    <= 1'b0;
      apb_penable <= 1'b0;
      apb_pwdata  <= '0;
      bad_pkt     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      bad_pkt <= take && !(is_rd || is_wr);
      busy    <= (state_d != IDLE);
      case (state)
        IDLE: begin
          if (take && is_rd) begin
            apb_paddr  <= req.addr;
            apb_pwrite <= 1'b0;
            apb_pwdata <= 32'd0;
            apb_psel   <= 1'b1;
          end else if (take && is_wr) begin
            apb_paddr  <= req.addr;
            apb_pwrite <= 1'b1;
            apb_pwdata <= req.wdata;
            apb_psel   <= 1'b1;
          end
        end
        SETUP: apb_penable <= 1'b1;
        ACCESS: begin
          if (acc_done) begin
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            a2l_valid   <= 1'b1;
            a2l_data    <= rsp_data;
          end
        end
        RSP: if (a2l_ready) a2l_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
